// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX bundle: decoded operands and control coming out of ID, and the
// registered copies presented to EX and the forwarding unit.
interface id_ex_stage_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  // ID side
  logic              ID_valid;
  logic [DATA_W-1:0] ID_pc;
  logic [DATA_W-1:0] ID_rs1_data;
  logic [DATA_W-1:0] ID_rs2_data;
  logic [DATA_W-1:0] ID_imm;
  logic [ADDR_W-1:0] ID_rs1;
  logic [ADDR_W-1:0] ID_rs2;
  logic [ADDR_W-1:0] ID_rd;
  logic              ID_use_rs1;
  logic              ID_use_rs2;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              ID_MemWrite;
  logic              ID_MemtoReg;
  logic              ID_ALUSrc;
  logic              ID_Branch;
  logic [3:0]        ID_ALUOp;

  // EX side (registered)
  logic              ID_EX_valid;
  logic [DATA_W-1:0] ID_EX_pc;
  logic [DATA_W-1:0] ID_EX_rs1_data;
  logic [DATA_W-1:0] ID_EX_rs2_data;
  logic [DATA_W-1:0] ID_EX_imm;
  logic [ADDR_W-1:0] ID_EX_rs1;
  logic [ADDR_W-1:0] ID_EX_rs2;
  logic [ADDR_W-1:0] ID_EX_rd;
  logic              ID_EX_RegWrite;
  logic              ID_EX_MemRead;
  logic              ID_EX_MemWrite;
  logic              ID_EX_MemtoReg;
  logic              ID_EX_ALUSrc;
  logic              ID_EX_Branch;
  logic [3:0]        ID_EX_ALUOp;

  // Decode stage side: produces ID fields, observes the ID/EX register
  modport master (
    output ID_valid, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
           ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_Branch, ID_ALUOp,
    input  ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
           ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp
  );

  // Pipeline register side
  modport slave (
    input  ID_valid, ID_pc, ID_rs1_data, ID_rs2_data, ID_imm,
           ID_rs1, ID_rs2, ID_rd, ID_use_rs1, ID_use_rs2,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_Branch, ID_ALUOp,
    output ID_EX_valid, ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm,
           ID_EX_rs1, ID_EX_rs2, ID_EX_rd,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection. A load in EX whose
// destination is read by the instruction in ID forces one bubble and freezes
// PC and IF/ID for that cycle. Taken-branch flush squashes, a data-memory
// stall freezes everything, and inserted load-use bubbles are counted.
module id_ex_stage #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_if.slave     bus,
  input  logic             flush,
  input  logic             mem_stall,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              memto_reg;
    logic              alu_src;
    logic              branch;
    logic [3:0]        alu_op;
  } stage_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t           stage_r;
  stage_t           stage_next_s;
  stage_t           capture_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             lu_s;
  logic             hz_s;

  // Load-use detection from the registered EX contents and the ID instruction
  always_comb begin
    lu_s = 1'b0;
    hz_s = 1'b0;
    if (stage_r.valid && stage_r.mem_read && (stage_r.rd != {ADDR_W{1'b0}}) &&
        bus.ID_valid &&
        ((bus.ID_use_rs1 && (bus.ID_rs1 == stage_r.rd)) ||
         (bus.ID_use_rs2 && (bus.ID_rs2 == stage_r.rd)))) begin
      lu_s = 1'b1;
    end else begin
      lu_s = 1'b0;
    end
    hz_s = lu_s & ~flush & ~mem_stall;
  end

  // Front-end enables; held open while reset is asserted
  always_comb begin
    PC_write    = 1'b1;
    IF_ID_write = 1'b1;
    if (!rst_n) begin
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
    end else begin
      PC_write    = ~hz_s & ~mem_stall;
      IF_ID_write = ~hz_s & ~mem_stall;
    end
  end

  // Gather the ID fields into one record for capture
  always_comb begin
    capture_s           = '0;
    capture_s.valid     = bus.ID_valid;
    capture_s.pc        = bus.ID_pc;
    capture_s.rs1_data  = bus.ID_rs1_data;
    capture_s.rs2_data  = bus.ID_rs2_data;
    capture_s.imm       = bus.ID_imm;
    capture_s.rs1       = bus.ID_rs1;
    capture_s.rs2       = bus.ID_rs2;
    capture_s.rd        = bus.ID_rd;
    capture_s.reg_write = bus.ID_RegWrite;
    capture_s.mem_read  = bus.ID_MemRead;
    capture_s.mem_write = bus.ID_MemWrite;
    capture_s.memto_reg = bus.ID_MemtoReg;
    capture_s.alu_src   = bus.ID_ALUSrc;
    capture_s.branch    = bus.ID_Branch;
    capture_s.alu_op    = bus.ID_ALUOp;
  end

  // Next-state selection: stall holds, flush and hazard load an all-zero bubble
  always_comb begin
    stage_next_s = stage_r;
    count_next_s = count_r;
    if (mem_stall) begin
      stage_next_s = stage_r;
      count_next_s = count_r;
    end else if (flush) begin
      stage_next_s = '0;
      count_next_s = count_r;
    end else if (hz_s) begin
      stage_next_s = '0;
      count_next_s = (count_r == CNT_MAX) ? count_r : (count_r + CNT_ONE);
    end else begin
      stage_next_s = capture_s;
      count_next_s = count_r;
    end
  end

  // Pipeline register and bubble counter, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_r <= '0;
      count_r <= '0;
    end else begin
      stage_r <= stage_next_s;
      count_r <= count_next_s;
    end
  end

  assign bus.ID_EX_valid    = stage_r.valid;
  assign bus.ID_EX_pc       = stage_r.pc;
  assign bus.ID_EX_rs1_data = stage_r.rs1_data;
  assign bus.ID_EX_rs2_data = stage_r.rs2_data;
  assign bus.ID_EX_imm      = stage_r.imm;
  assign bus.ID_EX_rs1      = stage_r.rs1;
  assign bus.ID_EX_rs2      = stage_r.rs2;
  assign bus.ID_EX_rd       = stage_r.rd;
  assign bus.ID_EX_RegWrite = stage_r.reg_write;
  assign bus.ID_EX_MemRead  = stage_r.mem_read;
  assign bus.ID_EX_MemWrite = stage_r.mem_write;
  assign bus.ID_EX_MemtoReg = stage_r.memto_reg;
  assign bus.ID_EX_ALUSrc   = stage_r.alu_src;
  assign bus.ID_EX_Branch   = stage_r.branch;
  assign bus.ID_EX_ALUOp    = stage_r.alu_op;
  assign bubble_count       = count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural model of the ID/EX
// register compared every cycle, directed scenarios with literal expectations,
// and a narrow-counter instance to reach saturation quickly.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        mem_stall;
  logic        PC_write;
  logic        IF_ID_write;
  logic [15:0] bubble_count;
  logic        sat_flush;
  logic        sat_stall;
  logic        sat_pc_write;
  logic        sat_if_id_write;
  logic [3:0]  sat_count;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  id_ex_stage_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  id_ex_stage_if #(.ADDR_W(5), .DATA_W(32)) sat_bus ();

  id_ex_stage #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush), .mem_stall(mem_stall),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .bubble_count(bubble_count)
  );

  id_ex_stage #(.ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sat_bus), .flush(sat_flush), .mem_stall(sat_stall),
    .PC_write(sat_pc_write), .IF_ID_write(sat_if_id_write), .bubble_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, m2r, asrc, br;
    logic [3:0]  op;
  } ex_t;

  ex_t         m;
  logic [15:0] m_cnt;

  // The load in EX writes a register the ID instruction really reads
  function automatic logic model_lu();
    logic load_in_ex;
    logic reads_it;
    load_in_ex = m.valid && m.mr && (m.rd != 5'd0);
    reads_it = bus.ID_valid && ((bus.ID_use_rs1 && bus.ID_rs1 == m.rd) ||
                                (bus.ID_use_rs2 && bus.ID_rs2 == m.rd));
    return load_in_ex && reads_it;
  endfunction

  function automatic logic model_enable();
    if (!rst_n) return 1'b1;
    return !(mem_stall || (model_lu() && !flush));
  endfunction

  task automatic model_edge();
    ex_t nxt;
    nxt = m;
    if (!rst_n) begin
      nxt = '0;
      m_cnt = 16'd0;
    end else if (mem_stall) begin
      nxt = m;
    end else if (flush) begin
      nxt = '0;
    end else if (model_lu()) begin
      nxt = '0;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      nxt.valid = bus.ID_valid;       nxt.pc = bus.ID_pc;
      nxt.rs1_data = bus.ID_rs1_data; nxt.rs2_data = bus.ID_rs2_data;
      nxt.imm = bus.ID_imm;
      nxt.rs1 = bus.ID_rs1; nxt.rs2 = bus.ID_rs2; nxt.rd = bus.ID_rd;
      nxt.rw = bus.ID_RegWrite; nxt.mr = bus.ID_MemRead; nxt.mw = bus.ID_MemWrite;
      nxt.m2r = bus.ID_MemtoReg; nxt.asrc = bus.ID_ALUSrc; nxt.br = bus.ID_Branch;
      nxt.op = bus.ID_ALUOp;
    end
    m = nxt;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", {63'd0, bus.ID_EX_valid}, {63'd0, m.valid});
      chk("pc", {32'd0, bus.ID_EX_pc}, {32'd0, m.pc});
      chk("rs1_data", {32'd0, bus.ID_EX_rs1_data}, {32'd0, m.rs1_data});
      chk("rs2_data", {32'd0, bus.ID_EX_rs2_data}, {32'd0, m.rs2_data});
      chk("imm", {32'd0, bus.ID_EX_imm}, {32'd0, m.imm});
      chk("rs1", {59'd0, bus.ID_EX_rs1}, {59'd0, m.rs1});
      chk("rs2", {59'd0, bus.ID_EX_rs2}, {59'd0, m.rs2});
      chk("rd", {59'd0, bus.ID_EX_rd}, {59'd0, m.rd});
      chk("ctrl", {58'd0, bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
                   bus.ID_EX_MemtoReg, bus.ID_EX_ALUSrc, bus.ID_EX_Branch},
                  {58'd0, m.rw, m.mr, m.mw, m.m2r, m.asrc, m.br});
      chk("aluop", {60'd0, bus.ID_EX_ALUOp}, {60'd0, m.op});
      chk("bubble_count", {48'd0, bubble_count}, {48'd0, m_cnt});
      chk("PC_write", {63'd0, PC_write}, {63'd0, model_enable()});
      chk("IF_ID_write", {63'd0, IF_ID_write}, {63'd0, model_enable()});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic rw, input logic mr);
    bus.ID_valid = v;       bus.ID_pc = pc;
    bus.ID_rs1_data = pc ^ 32'hA5A5_0000;
    bus.ID_rs2_data = pc + 32'd1;
    bus.ID_imm = ~pc;
    bus.ID_rs1 = rs1; bus.ID_rs2 = rs2; bus.ID_rd = rd;
    bus.ID_use_rs1 = u1; bus.ID_use_rs2 = u2;
    bus.ID_RegWrite = rw; bus.ID_MemRead = mr; bus.ID_MemWrite = 1'b0;
    bus.ID_MemtoReg = mr; bus.ID_ALUSrc = mr; bus.ID_Branch = 1'b0;
    bus.ID_ALUOp = pc[3:0];
  endtask

  task automatic drive_random();
    bus.ID_valid = 1'($urandom_range(0, 1));
    bus.ID_pc = $urandom; bus.ID_rs1_data = $urandom; bus.ID_rs2_data = $urandom;
    bus.ID_imm = $urandom;
    bus.ID_rs1 = 5'($urandom_range(0, 3)); bus.ID_rs2 = 5'($urandom_range(0, 3));
    bus.ID_rd = 5'($urandom_range(0, 3));
    bus.ID_use_rs1 = 1'($urandom_range(0, 1)); bus.ID_use_rs2 = 1'($urandom_range(0, 1));
    bus.ID_RegWrite = 1'($urandom_range(0, 1)); bus.ID_MemRead = 1'($urandom_range(0, 1));
    bus.ID_MemWrite = 1'($urandom_range(0, 1)); bus.ID_MemtoReg = 1'($urandom_range(0, 1));
    bus.ID_ALUSrc = 1'($urandom_range(0, 1)); bus.ID_Branch = 1'($urandom_range(0, 1));
    bus.ID_ALUOp = 4'($urandom_range(0, 15));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    m = '0;
    m_cnt = 16'd0;
    sat_flush = 1'b0; sat_stall = 1'b0;
    sat_bus.ID_valid = 1'b0; sat_bus.ID_pc = 32'd0; sat_bus.ID_rs1_data = 32'd0;
    sat_bus.ID_rs2_data = 32'd0; sat_bus.ID_imm = 32'd0;
    sat_bus.ID_rs1 = 5'd0; sat_bus.ID_rs2 = 5'd0; sat_bus.ID_rd = 5'd0;
    sat_bus.ID_use_rs1 = 1'b0; sat_bus.ID_use_rs2 = 1'b0;
    sat_bus.ID_RegWrite = 1'b0; sat_bus.ID_MemRead = 1'b0; sat_bus.ID_MemWrite = 1'b0;
    sat_bus.ID_MemtoReg = 1'b0; sat_bus.ID_ALUSrc = 1'b0; sat_bus.ID_Branch = 1'b0;
    sat_bus.ID_ALUOp = 4'd0;

    // Reset with random ID inputs
    rst_n = 1'b0;
    flush = 1'($urandom_range(0, 1));
    mem_stall = 1'($urandom_range(0, 1));
    drive_random();
    tick();
    chk_en = 1'b1;
    drive_random();
    tick();
    chk("rst_valid", {63'd0, bus.ID_EX_valid}, 64'd0);
    chk("rst_pc", {32'd0, bus.ID_EX_pc}, 64'd0);
    chk("rst_count", {48'd0, bubble_count}, 64'd0);
    chk("rst_pc_write", {63'd0, PC_write}, 64'd1);

    // Pass-through
    rst_n = 1'b1; flush = 1'b0; mem_stall = 1'b0;
    drive(1'b1, 32'h100, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pass_pc", {32'd0, bus.ID_EX_pc}, 64'h100);
    chk("pass_rs1", {59'd0, bus.ID_EX_rs1}, 64'd5);
    chk("pass_rd", {59'd0, bus.ID_EX_rd}, 64'd7);
    chk("pass_valid", {63'd0, bus.ID_EX_valid}, 64'd1);

    // Load-use: lw x6 then add using rs2=x6
    drive(1'b1, 32'h104, 5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h108, 5'd1, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("lu_pc_write", {63'd0, PC_write}, 64'd0);
    chk("lu_if_id_write", {63'd0, IF_ID_write}, 64'd0);
    tick();
    chk("lu_bubble_valid", {63'd0, bus.ID_EX_valid}, 64'd0);
    chk("lu_bubble_rd", {59'd0, bus.ID_EX_rd}, 64'd0);
    chk("lu_count", {48'd0, bubble_count}, 64'd1);
    chk("lu_released", {63'd0, PC_write}, 64'd1);
    tick();
    chk("lu_add_rd", {59'd0, bus.ID_EX_rd}, 64'd8);
    chk("lu_add_pc", {32'd0, bus.ID_EX_pc}, 64'h108);

    // lw x0 then use of x0: no bubble
    drive(1'b1, 32'h10C, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h110, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    chk("x0_pc_write", {63'd0, PC_write}, 64'd1);
    tick();
    chk("x0_valid", {63'd0, bus.ID_EX_valid}, 64'd1);

    // lw x6 then rs1=6 but not used: no bubble
    drive(1'b1, 32'h114, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h118, 5'd6, 5'd3, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("nouse_pc_write", {63'd0, PC_write}, 64'd1);
    tick();
    chk("nouse_count", {48'd0, bubble_count}, 64'd1);

    // Flush beats load-use
    drive(1'b1, 32'h11C, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h120, 5'd6, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_pc_write", {63'd0, PC_write}, 64'd1);
    tick();
    flush = 1'b0;
    chk("flush_valid", {63'd0, bus.ID_EX_valid}, 64'd0);
    chk("flush_count", {48'd0, bubble_count}, 64'd1);

    // mem_stall freezes with a pending hazard, then exactly one bubble
    drive(1'b1, 32'h200, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 5'd6, 5'd1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      chk("stall_pc_write", {63'd0, PC_write}, 64'd0);
      tick();
      chk("stall_frozen_pc", {32'd0, bus.ID_EX_pc}, 64'h200);
    end
    mem_stall = 1'b0;
    #1;
    chk("release_pc_write", {63'd0, PC_write}, 64'd0);
    tick();
    chk("release_bubble", {63'd0, bus.ID_EX_valid}, 64'd0);
    chk("release_count", {48'd0, bubble_count}, 64'd2);
    tick();
    chk("release_capture", {32'd0, bus.ID_EX_pc}, 64'h308);
    chk("release_count2", {48'd0, bubble_count}, 64'd2);

    // Back-to-back loads with a dependency chain: one bubble each
    drive(1'b1, 32'h400, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h404, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    drive(1'b1, 32'h408, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    chk("chain_count", {48'd0, bubble_count}, 64'd4);
    chk("chain_rd", {59'd0, bus.ID_EX_rd}, 64'd9);

    // Reset in the middle of a stall
    drive(1'b1, 32'h500, 5'd0, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h504, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    mem_stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_stall_pc_write", {63'd0, PC_write}, 64'd1);
    tick();
    chk("rst_stall_valid", {63'd0, bus.ID_EX_valid}, 64'd0);
    chk("rst_stall_count", {48'd0, bubble_count}, 64'd0);
    rst_n = 1'b1;
    mem_stall = 1'b0;

    // Randomised traffic checked against the model
    for (int i = 0; i < 300; i++) begin
      drive_random();
      flush = ($urandom_range(0, 7) == 0);
      mem_stall = ($urandom_range(0, 7) == 0);
      tick();
    end
    flush = 1'b0;
    mem_stall = 1'b0;

    // Saturation on the 4-bit instance: a self-dependent load yields a bubble every 2 cycles
    sat_bus.ID_valid = 1'b1; sat_bus.ID_MemRead = 1'b1; sat_bus.ID_RegWrite = 1'b1;
    sat_bus.ID_rd = 5'd6; sat_bus.ID_rs1 = 5'd6; sat_bus.ID_use_rs1 = 1'b1;
    for (int i = 0; i < 28; i++) tick();
    chk("sat_count_14", {60'd0, sat_count}, 64'd14);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_count_16", {60'd0, sat_count}, 64'hF);
    for (int i = 0; i < 4; i++) tick();
    chk("sat_count_18", {60'd0, sat_count}, 64'hF);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I pipeline, plus load-use hazard detection.
- Captures decoded operands and control from ID, then presents ID_EX_rs1/rs2/rd, RegWrite and MemRead to EX and to the forwarding unit.
- Inserts one bubble when an instruction in ID needs a register that a load currently in EX will write, and stalls PC and IF/ID while it does.
- Squashes on a taken branch, holds on a data-memory stall, and counts inserted bubbles.

Parameters:
- ADDR_W, 5, register address width (matches REG_ADDR_WIDTH).
- DATA_W, 32, register/immediate/PC data width (matches REG_DATA_WIDTH).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous active-low reset
- ID_valid  in  1  ID holds a real instruction
- ID_pc  in  DATA_W  PC of the ID instruction
- ID_rs1_data, ID_rs2_data  in  DATA_W  register file read data
- ID_imm  in  DATA_W  sign-extended immediate
- ID_rs1, ID_rs2, ID_rd  in  ADDR_W  register addresses
- ID_use_rs1, ID_use_rs2  in  1  instruction actually reads rs1/rs2
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch  in  1  control bits
- ID_ALUOp  in  4  ALU operation
- flush  in  1  taken branch/jump resolved in EX
- mem_stall  in  1  data memory busy; whole pipeline frozen
- ID_EX_valid  out  1  registered valid
- ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm  out  DATA_W  registered
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  ADDR_W  registered; rs1/rs2 feed the forwarding unit
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch  out  1  registered
- ID_EX_ALUOp  out  4  registered
- PC_write, IF_ID_write  out  1  combinational enables to the IF stage and the IF/ID register
- bubble_count  out  CNT_W  saturating count of load-use bubbles inserted

Behaviour:
- Reset (rst_n=0 at a clk edge): every registered output goes to 0, including bubble_count.
  - Reset has priority over every other input.
  - Reset asserted in mid-stall clears state; there is no carry-over.
- Hazard detection (combinational, from the current registered state):
  - lu = ID_EX_valid & ID_EX_MemRead & (ID_EX_rd != 0) & ID_valid & ((ID_use_rs1 & ID_rs1 == ID_EX_rd) | (ID_use_rs2 & ID_rs2 == ID_EX_rd)).
  - hz = lu & ~flush & ~mem_stall.
- Stall enables: PC_write = IF_ID_write = ~hz & ~mem_stall. Both are 1 while reset is asserted.
- Register update at each clk edge, first matching rule wins:
  1. mem_stall=1: hold all registers, including the counter.
  2. flush=1: load a bubble.
  3. hz=1: load a bubble; bubble_count += 1, saturating at all-ones.
  4. Otherwise: capture all ID_* inputs, with ID_EX_valid = ID_valid.
- Bubble definition:
  - valid, RegWrite, MemRead, MemWrite and Branch are 0.
  - rd, rs1 and rs2 are 0, so the forwarding unit never matches a bubble.
  - Data fields and the remaining control bits are don't-care; drive them 0.
- Latency:
  - ID inputs appear on ID_EX_* one cycle after capture.
  - A load-use hazard costs exactly one bubble. On the following cycle the load has moved on, so lu=0 and the ID instruction is captured; forwarding then supplies the value from MEM/WB.
- Simultaneous events:
  - flush with lu: flush wins and the counter does not increment.
  - mem_stall with flush or lu: hold, and PC_write=0.
  - A second load back-to-back with a dependent instruction is still one bubble per dependency.
- Register x0: rd=0 never raises a hazard.
- Single clock domain; no combinational path from flush or mem_stall to the registered outputs.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random ID inputs -> all registered outputs 0, bubble_count=0, PC_write=1.
- Pass-through: ID_valid=1, ID_pc=0x100, ID_rs1=5, ID_rd=7, ID_RegWrite=1 -> next cycle ID_EX_pc=0x100, ID_EX_rs1=5, ID_EX_rd=7, ID_EX_valid=1.
- Load-use:
  - Stimulus: lw x6 captured, then ID holds add using rs2=6.
  - Cycle 1: PC_write=IF_ID_write=0, and the next cycle shows a bubble (ID_EX_valid=0, rd=0) with bubble_count=1.
  - Cycle 2: the add is captured and PC_write=1.
- No hazard:
  - lw x0 followed by a use of x0 -> no bubble.
  - lw x6 followed by an instruction with ID_use_rs1=0 and ID_rs1=6 -> no bubble.
- Flush priority: flush=1 while lu=1 -> bubble loaded, bubble_count unchanged, PC_write=1.
- mem_stall: hold 3 cycles with changing ID inputs -> outputs frozen, PC_write=0. After release, the pending load-use bubble is inserted exactly once.
- Saturation: force 2^CNT_W+2 bubbles -> bubble_count holds at 0xFFFF.
